// File: rtl/mul_sequencer.sv
// Multi-cycle signed shift-add multiplier beside the EX-stage ALU.
// A MUL request stalls the pipeline for WIDTH+1 cycles. The 2*WIDTH product
// is then presented with a one-cycle done_o pulse. Other ALU operations pass
// through without stalling.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   valid_i     EX stage holds a valid instruction
//   alu_ctrl_i  decoded ALU control code
//   flush_i     pipeline flush; aborts a multiply in progress
//   data1_i     multiplicand (two's complement)
//   data2_i     multiplier (two's complement)
//   stall_o     freezes PC, IF/ID and ID/EX (combinational)
//   busy_o      high while the multiply is running
//   done_o      one-cycle pulse; product_o valid
//   product_o   signed product {hi, lo}
module mul_sequencer #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [2:0]  MUL_CTRL = 3'b011
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [2:0]           alu_ctrl_i,
  input  logic                 flush_i,
  input  logic [WIDTH-1:0]     data1_i,
  input  logic [WIDTH-1:0]     data2_i,
  output logic                 stall_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [CW-1:0]    count_q,   count_d;
  logic [WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q,  mplier_d;
  logic             neg_q,     neg_d;
  logic [PW-1:0]    acc_q,     acc_d;
  logic [PW-1:0]    product_q, product_d;

  logic             req_c;
  logic [PW-1:0]    acc_sum_c;

  assign req_c = valid_i && (alu_ctrl_i == MUL_CTRL) && !flush_i;

  // Accumulator including this step's partial product.
  assign acc_sum_c = acc_q + (mplier_q[0] ? (PW'(mcand_q) << count_q) : {PW{1'b0}});

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          // Magnitudes are unsigned, so the most-negative operand still fits.
          mcand_d  = data1_i[WIDTH-1] ? (~data1_i + WIDTH'(1)) : data1_i;
          mplier_d = data2_i[WIDTH-1] ? (~data2_i + WIDTH'(1)) : data2_i;
          neg_d    = data1_i[WIDTH-1] ^ data2_i[WIDTH-1];
          acc_d    = {PW{1'b0}};
          count_d  = {CW{1'b0}};
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d    = acc_sum_c;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_d   = S_DONE;
            product_d = neg_q ? (~acc_sum_c + PW'(1)) : acc_sum_c;
          end
        end
      end
      // The finished instruction is still in EX, so a request here is ignored.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      count_q   <= {CW{1'b0}};
      mcand_q   <= {WIDTH{1'b0}};
      mplier_q  <= {WIDTH{1'b0}};
      neg_q     <= 1'b0;
      acc_q     <= {PW{1'b0}};
      product_q <= {PW{1'b0}};
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign stall_o   = ((state_q == S_IDLE) && req_c) || (state_q == S_RUN);
  assign busy_o    = (state_q == S_RUN);
  assign done_o    = (state_q == S_DONE);
  assign product_o = product_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer (WIDTH=32): a scoreboard of expected
// products is compared by a monitor at every done_o pulse.
module tb_mul_sequencer;

  localparam int unsigned W = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic [2:0]    alu_ctrl_i;
  logic          flush_i;
  logic [W-1:0]  data1_i;
  logic [W-1:0]  data2_i;
  logic          stall_o;
  logic          busy_o;
  logic          done_o;
  logic [2*W-1:0] product_o;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  mul_sequencer #(.WIDTH(W), .MUL_CTRL(3'b011)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .alu_ctrl_i(alu_ctrl_i),
    .flush_i(flush_i), .data1_i(data1_i), .data2_i(data2_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .product_o(product_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain signed multiplication of the two operands.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("product", product_o, mon_e);
      end
    end
  end

  task automatic idle();
    valid_i = 1'b0; alu_ctrl_i = 3'b000; flush_i = 1'b0;
  endtask

  // Called just after a rising edge; holds the request until done, returns
  // just after the edge that ends the DONE cycle with the request still driven.
  task automatic mul_op(input logic [31:0] a, input logic [31:0] b);
    int cyc, nst;
    bit seen;
    valid_i = 1'b1; alu_ctrl_i = 3'b011; flush_i = 1'b0;
    data1_i = a; data2_i = b;
    exp_q.push_back(ref_mul(a, b));
    cyc = 0; nst = 0; seen = 0;
    while (cyc < 100) begin
      @(negedge clk_i);
      if (cyc == 0) begin
        chk("start_busy", 64'(busy_o), 64'd0);
        chk("start_stall", 64'(stall_o), 64'd1);
      end
      if (done_o) begin
        seen = 1;
        break;
      end
      if (stall_o) nst++;
      cyc++;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("done_latency", 64'(cyc), 64'd33);
    chk("stall_cycles", 64'(nst), 64'd33);
    @(posedge clk_i); #1;
  endtask

  task automatic expect_prod(input string name, input logic [63:0] v);
    @(negedge clk_i);
    chk(name, product_o, v);
    @(posedge clk_i); #1;
  endtask

  // Starts a multiply and returns just after the edge into RUN count=10.
  task automatic start_to_count10(input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1; alu_ctrl_i = 3'b011; flush_i = 1'b0;
    data1_i = a; data2_i = b;
    repeat (11) @(posedge clk_i);
    #1;
  endtask

  logic [31:0] ra, rb;
  int base_done;

  initial begin
    rst_i = 1'b1; data1_i = '0; data2_i = '0;
    idle();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_product", product_o, 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Directed products.
    mul_op(32'd6, 32'd7);                 idle(); expect_prod("p_6x7", 64'h0000_0000_0000_002A);
    mul_op(-32'sd3, 32'd5);               idle(); expect_prod("p_m3x5", 64'hFFFF_FFFF_FFFF_FFF1);
    mul_op(-32'sd3, -32'sd5);             idle(); expect_prod("p_m3xm5", 64'h0000_0000_0000_000F);
    mul_op(32'h8000_0000, 32'h8000_0000); idle(); expect_prod("p_minxmin", 64'h4000_0000_0000_0000);
    mul_op(32'h8000_0000, 32'd1);         idle(); expect_prod("p_minx1", 64'hFFFF_FFFF_8000_0000);

    // Non-MUL operation: no stall, no start.
    valid_i = 1'b1; alu_ctrl_i = 3'b010; data1_i = 32'd9; data2_i = 32'd9;
    @(negedge clk_i);
    chk("add_stall", 64'(stall_o), 64'd0);
    chk("add_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    chk("add_busy_next", 64'(busy_o), 64'd0);
    @(posedge clk_i); #1; idle();

    // Back-to-back: second request starts in the cycle after DONE.
    mul_op(32'd123, 32'd456);
    mul_op(-32'sd77, 32'd1000);
    idle();

    // Flush mid-RUN: no done, product held.
    mul_op(32'd6, 32'd7); idle();
    base_done = done_seen;
    start_to_count10(32'd11, 32'd13);
    flush_i = 1'b1; valid_i = 1'b0;
    @(posedge clk_i); #1; idle();
    @(negedge clk_i);
    chk("flush_busy", 64'(busy_o), 64'd0);
    chk("flush_done", 64'(done_o), 64'd0);
    repeat (40) @(negedge clk_i);
    chk("flush_no_done", 64'(done_seen), 64'(base_done));
    chk("flush_hold", product_o, 64'h0000_0000_0000_002A);
    @(posedge clk_i); #1;

    // Reset mid-RUN: outputs back to reset values.
    start_to_count10(32'd11, 32'd13);
    rst_i = 1'b1; valid_i = 1'b0;
    @(posedge clk_i); #1; rst_i = 1'b0; idle();
    @(negedge clk_i);
    chk("rstrun_busy", 64'(busy_o), 64'd0);
    chk("rstrun_done", 64'(done_o), 64'd0);
    chk("rstrun_product", product_o, 64'd0);
    @(posedge clk_i); #1;

    // Flush together with a request in IDLE: masked.
    valid_i = 1'b1; alu_ctrl_i = 3'b011; flush_i = 1'b1; data1_i = 32'd3; data2_i = 32'd4;
    @(negedge clk_i);
    chk("flushreq_stall", 64'(stall_o), 64'd0);
    @(negedge clk_i);
    chk("flushreq_busy", 64'(busy_o), 64'd0);
    @(posedge clk_i); #1; idle();

    // Reset together with a request: stays IDLE.
    rst_i = 1'b1; valid_i = 1'b1; alu_ctrl_i = 3'b011;
    @(posedge clk_i); #1; rst_i = 1'b0; idle();
    @(negedge clk_i);
    chk("rstreq_busy", 64'(busy_o), 64'd0);
    chk("rstreq_stall", 64'(stall_o), 64'd0);
    @(posedge clk_i); #1;

    // Randomized operands, including boundary values.
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: rb = 32'h7FFF_FFFF;
        1: rb = 32'h0000_0000;
        default: rb = $urandom;
      endcase
      mul_op(ra, rb);
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();
    repeat (3) @(negedge clk_i);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
